// File: rtl/rram_row_sequencer.sv
// -----------------------------------------------------------------------------
// rram_row_sequencer
//   Sequences the wordline, bitline-level and Dback controls of a ROWS-row RRAM
//   crossbar column. One command at a time (CLEAR, PROGRAM, INFER, BACKPROP) is
//   accepted over a valid/ready handshake. PROGRAM turns the weight code into a
//   set pulse of weight*PULSE_UNIT cycles. The per-row wordline enables are
//   persistent: a cell keeps its conductance only while its wordline is high.
//
// Optional feature (compile-time macro RRAM_WEAR_CNT_EN):
//   adds wear_cnt, one saturating 8-bit PROGRAM counter per row.
//
// Ports
//   clk          system clock
//   rst          asynchronous, active-high reset (clears every cell)
//   cmd_valid    command request
//   cmd_ready    high only while idle
//   cmd_op       0=CLEAR 1=PROGRAM 2=INFER 3=BACKPROP
//   cmd_row      target row
//   cmd_weight   weight code (PROGRAM only)
//   wl           wordline enables (persistent register)
//   bl_level     0=0 V, 1=back level, 2=set level (3 never driven)
//   dback        back-propagation enable
//   infer_valid  one-cycle pulse: cell output may be sampled
//   done         one-cycle pulse at the end of every accepted command
//   err          one-cycle pulse with done when the command was rejected
//   wear_cnt     {row3..row0} 8-bit program counters (RRAM_WEAR_CNT_EN only)
// -----------------------------------------------------------------------------
module rram_row_sequencer #(
  parameter int ROWS       = 4,
  parameter int WW         = 6,
  parameter int PULSE_UNIT = 1,
  parameter int SETTLE     = 3,
  parameter int BP_CYC     = 2,
  parameter int CLR_CYC    = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [1:0]              cmd_op,
  input  logic [$clog2(ROWS)-1:0] cmd_row,
  input  logic [WW-1:0]           cmd_weight,
  output logic [ROWS-1:0]         wl,
  output logic [1:0]              bl_level,
  output logic                    dback,
  output logic                    infer_valid,
  output logic                    done,
  output logic                    err
`ifdef RRAM_WEAR_CNT_EN
  ,
  output logic [ROWS*8-1:0]       wear_cnt
`endif
);

  localparam int RW        = $clog2(ROWS);
  localparam int PULSE_MAX = ((1 << WW) - 1) * PULSE_UNIT;
  localparam int MAX_A     = (SETTLE > CLR_CYC) ? SETTLE : CLR_CYC;
  localparam int MAX_B     = (BP_CYC > PULSE_MAX) ? BP_CYC : PULSE_MAX;
  localparam int MAX_CNT   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W     = $clog2(MAX_CNT + 1);

  // Phase counters are loaded with length-1 and count down to zero.
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE - 1);
  localparam logic [CNT_W-1:0] BP_LD     = CNT_W'(BP_CYC - 1);
  localparam logic [CNT_W-1:0] CLR_LD    = CNT_W'(CLR_CYC - 1);

  typedef enum logic [1:0] {
    OP_CLEAR    = 2'd0,
    OP_PROGRAM  = 2'd1,
    OP_INFER    = 2'd2,
    OP_BACKPROP = 2'd3
  } op_e;

  typedef enum logic [3:0] {
    S_IDLE, S_WL_SET, S_SETTLE_W, S_PULSE, S_SETTLE_P,
    S_CLR_LOW, S_READ, S_BP_LVL, S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  op_e               op_q, op_d;
  logic [RW-1:0]     row_q, row_d;
  logic [WW-1:0]     weight_q, weight_d;
  logic              rej_q, rej_d;
  logic [ROWS-1:0]   wl_q, wl_d;
  logic [CNT_W-1:0]  pulse_len;

  assign pulse_len = CNT_W'(weight_q) * CNT_W'(PULSE_UNIT);
  assign wl        = wl_q;

  always_comb begin
    // NOTE: every signal written here gets a default first; a path that left
    // one unassigned would infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    row_d       = row_q;
    weight_d    = weight_q;
    rej_d       = rej_q;
    wl_d        = wl_q;
    cmd_ready   = 1'b0;
    bl_level    = 2'd0;
    dback       = 1'b0;
    infer_valid = 1'b0;
    done        = 1'b0;
    err         = 1'b0;

    case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          op_d     = op_e'(cmd_op);
          row_d    = cmd_row;
          weight_d = cmd_weight;
          rej_d    = 1'b0;
          case (op_e'(cmd_op))
            OP_CLEAR: begin
              state_d       = S_CLR_LOW;
              cnt_d         = CLR_LD;
              wl_d[cmd_row] = 1'b0;
            end
            OP_PROGRAM: begin
              // An already-enabled row is cleared first so no stale
              // conductance survives into the new weight.
              if (wl_q[cmd_row]) begin
                state_d       = S_CLR_LOW;
                cnt_d         = CLR_LD;
                wl_d[cmd_row] = 1'b0;
              end else begin
                state_d       = S_WL_SET;
                wl_d[cmd_row] = 1'b1;
              end
            end
            default: begin  // INFER, BACKPROP
              if (!wl_q[cmd_row]) begin
                // Rejected: one quiet cycle (bitline at 0, no dback) then DONE.
                rej_d   = 1'b1;
                state_d = S_READ;
                cnt_d   = '0;
              end else if (op_e'(cmd_op) == OP_INFER) begin
                state_d = S_READ;
                cnt_d   = SETTLE_LD;
              end else begin
                state_d = S_BP_LVL;
                cnt_d   = BP_LD;
              end
            end
          endcase
        end
      end

      S_WL_SET: begin
        state_d = S_SETTLE_W;
        cnt_d   = SETTLE_LD;
      end

      S_SETTLE_W: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - ONE;
        end else if (pulse_len == '0) begin
          state_d = S_DONE;  // zero weight: row enabled, no set pulse
        end else begin
          state_d = S_PULSE;
          cnt_d   = pulse_len - ONE;
        end
      end

      S_PULSE: begin
        bl_level = 2'd2;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - ONE;
        end else begin
          state_d = S_SETTLE_P;
          cnt_d   = SETTLE_LD;
        end
      end

      S_SETTLE_P: begin
        // After a back-propagation the enable is held one cycle past the
        // level's fall so that fall never acts as a dback-qualified edge.
        dback = (op_q == OP_BACKPROP) && (cnt_q == SETTLE_LD);
        if (cnt_q != '0) cnt_d = cnt_q - ONE;
        else             state_d = S_DONE;
      end

      S_CLR_LOW: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - ONE;
        end else if (op_q == OP_PROGRAM) begin
          state_d     = S_WL_SET;
          wl_d[row_q] = 1'b1;
        end else begin
          state_d = S_DONE;
        end
      end

      S_READ: begin
        infer_valid = !rej_q && (cnt_q == '0);
        if (cnt_q != '0) cnt_d = cnt_q - ONE;
        else             state_d = S_DONE;
      end

      S_BP_LVL: begin
        bl_level = 2'd1;
        dback    = 1'b1;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - ONE;
        end else begin
          state_d = S_SETTLE_P;
          cnt_d   = SETTLE_LD;
        end
      end

      S_DONE: begin
        done    = 1'b1;
        err     = rej_q;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= OP_CLEAR;
      row_q    <= '0;
      weight_q <= '0;
      rej_q    <= 1'b0;
      wl_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      row_q    <= row_d;
      weight_q <= weight_d;
      rej_q    <= rej_d;
      wl_q     <= wl_d;
    end
  end

`ifdef RRAM_WEAR_CNT_EN
  logic [7:0] wear_q [ROWS];
  logic [7:0] wear_d [ROWS];

  always_comb begin
    for (int r = 0; r < ROWS; r++) begin
      wear_d[r] = wear_q[r];
      if (cmd_valid && cmd_ready && (op_e'(cmd_op) == OP_PROGRAM) &&
          (cmd_row == RW'(r)) && (wear_q[r] != 8'hFF))
        wear_d[r] = wear_q[r] + 8'd1;
    end
  end

  // NOTE: this small counter array is reset because its contents are visible
  // state; a bulk storage array would normally be left unreset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < ROWS; r++) wear_q[r] <= '0;
    end else begin
      for (int r = 0; r < ROWS; r++) wear_q[r] <= wear_d[r];
    end
  end

  for (genvar g = 0; g < ROWS; g++) begin : g_wear
    assign wear_cnt[g*8 +: 8] = wear_q[g];
  end
`endif

endmodule
